// File: rtl/perspective_params_seq.sv
// Perspective-parameter engine: forward params, adjugate inverse, horizontal decrements.
// One shared signed multiplier is time-multiplexed by a small FSM, once per frame.
module perspective_params_seq #(
  parameter int XW     = 10,
  parameter int YW     = 9,
  parameter int OW     = 80,
  parameter int K7     = 3,
  parameter int K8     = 4,
  parameter int K9     = 1920,
  parameter int HSCALE = 639
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [XW-1:0]        x1,
  input  logic [XW-1:0]        x2,
  input  logic [XW-1:0]        x3,
  input  logic [XW-1:0]        x4,
  input  logic [YW-1:0]        y1,
  input  logic [YW-1:0]        y2,
  input  logic [YW-1:0]        y3,
  input  logic [YW-1:0]        y4,
  output logic                 busy,
  output logic                 done,
  output logic                 degenerate,
  output logic signed [OW-1:0] p1_inv,
  output logic signed [OW-1:0] p2_inv,
  output logic signed [OW-1:0] p3_inv,
  output logic signed [OW-1:0] p4_inv,
  output logic signed [OW-1:0] p5_inv,
  output logic signed [OW-1:0] p6_inv,
  output logic signed [OW-1:0] p7_inv,
  output logic signed [OW-1:0] p8_inv,
  output logic signed [OW-1:0] p9_inv,
  output logic signed [OW-1:0] dec_numx_horiz,
  output logic signed [OW-1:0] dec_numy_horiz,
  output logic signed [OW-1:0] dec_denom_horiz
);

  localparam int DXW = XW + 1;
  localparam int DYW = YW + 1;
  localparam int CW  = (DXW > DYW) ? DXW : DYW;
  localparam int DW  = DXW + DYW + 2;
  localparam int KA  = (K7 > K8) ? K7 : K8;
  localparam int KM  = (K9 > KA) ? K9 : KA;
  localparam int KW  = $clog2(KM + 1) + 1;
  localparam int FW  = KW + CW + DW + 2;
  localparam int AW  = 2 * FW + 1;

  typedef enum logic [2:0] {
    IDLE, CAPT, FWD, INV, SCALE
  } state_t;

  state_t state, nxt;
  logic [4:0] cnt;
  logic [3:0] aidx;
  logic cap, dif_en, fwd_en, inv_en, ld_en;

  logic signed [DXW-1:0] cx1, cx2, cx3, cx4;
  logic signed [DXW-1:0] dx14, dx23, dx12, dx43;
  logic signed [DYW-1:0] cy1, cy2, cy3, cy4;
  logic signed [DYW-1:0] dy23, dy41, dy34, dy12, dy42;

  logic signed [FW-1:0] s7, s8, den, xd, yd;
  logic signed [FW-1:0] p1, p2, p4, p5;
  logic signed [FW-1:0] p3, p6, p7, p8, p9;
  logic signed [FW-1:0] ma, mb, pf, pk7, pk8;
  logic signed [2*FW-1:0] prod;
  logic signed [AW-1:0] acc [9];

  // constant multiply as a shift-add chain
  function automatic logic signed [AW-1:0] cmul(
    input logic signed [AW-1:0] a,
    input int k
  );
    logic signed [AW-1:0] r;
    r = '0;
    for (int i = 0; i < 31; i++)
      if (k[i]) r = r + (a <<< i);
    return r;
  endfunction

  assign p7   = FW'(cmul(AW'(s7), K7));
  assign p8   = FW'(cmul(AW'(s8), K8));
  assign p9   = FW'(cmul(AW'(den), K9));
  assign p3   = FW'(cmul(AW'(xd), K9));
  assign p6   = FW'(cmul(AW'(yd), K9));
  assign prod = (2*FW)'(ma) * (2*FW)'(mb);
  assign pf   = FW'(prod);
  assign pk7  = FW'(cmul(AW'(pf), K7));
  assign pk8  = FW'(cmul(AW'(pf), K8));
  assign aidx = cnt[4:1];

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = CAPT;
      CAPT:    nxt = FWD;
      FWD:     if (cnt == 5'd16) nxt = INV;
      INV:     if (cnt == 5'd17) nxt = SCALE;
      SCALE:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // per-state datapath enables
  always_comb begin
    cap    = 1'b0;
    dif_en = 1'b0;
    fwd_en = 1'b0;
    inv_en = 1'b0;
    ld_en  = 1'b0;
    case (state)
      IDLE:    cap    = start;
      CAPT:    dif_en = 1'b1;
      FWD:     fwd_en = 1'b1;
      INV:     inv_en = 1'b1;
      SCALE:   ld_en  = 1'b1;
      default: ;
    endcase
  end

  // step counter, cleared on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (nxt != state)     cnt <= '0;
    else if (fwd_en || inv_en) cnt <= cnt + 5'd1;
  end

  // busy lags the state by one cycle; done marks the load cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state != IDLE);
      done <= ld_en;
    end
  end

  // operand select for the shared multiplier
  always_comb begin
    ma = '0;
    mb = '0;
    if (fwd_en) begin
      case (cnt)
        5'd0:  begin ma = FW'(dx14); mb = FW'(dy23); end
        5'd1:  begin ma = FW'(dy41); mb = FW'(dx23); end
        5'd2:  begin ma = FW'(dx12); mb = FW'(dy34); end
        5'd3:  begin ma = FW'(dx43); mb = FW'(dy12); end
        5'd4:  begin ma = FW'(cx4);  mb = FW'(dy23); end
        5'd5:  begin ma = FW'(cx2);  mb = FW'(dy34); end
        5'd6:  begin ma = FW'(cx3);  mb = FW'(dy42); end
        5'd7:  begin ma = FW'(cx1);  mb = den; end
        5'd8:  begin ma = FW'(cy1);  mb = den; end
        5'd9:  begin ma = FW'(dx14); mb = den; end
        5'd10: begin ma = FW'(dx12); mb = den; end
        5'd11: begin ma = FW'(dy41); mb = den; end
        5'd12: begin ma = FW'(dy12); mb = den; end
        5'd13: begin ma = FW'(cx4);  mb = p7; end
        5'd14: begin ma = FW'(cx2);  mb = p8; end
        5'd15: begin ma = FW'(cy4);  mb = p7; end
        5'd16: begin ma = FW'(cy2);  mb = p8; end
        default: ;
      endcase
    end else if (inv_en) begin
      case (cnt)
        5'd0:  begin ma = p6; mb = p8; end
        5'd1:  begin ma = p5; mb = p9; end
        5'd2:  begin ma = p2; mb = p9; end
        5'd3:  begin ma = p3; mb = p8; end
        5'd4:  begin ma = p3; mb = p5; end
        5'd5:  begin ma = p2; mb = p6; end
        5'd6:  begin ma = p4; mb = p9; end
        5'd7:  begin ma = p6; mb = p7; end
        5'd8:  begin ma = p3; mb = p7; end
        5'd9:  begin ma = p1; mb = p9; end
        5'd10: begin ma = p1; mb = p6; end
        5'd11: begin ma = p3; mb = p4; end
        5'd12: begin ma = p5; mb = p7; end
        5'd13: begin ma = p4; mb = p8; end
        5'd14: begin ma = p1; mb = p8; end
        5'd15: begin ma = p2; mb = p7; end
        5'd16: begin ma = p2; mb = p4; end
        5'd17: begin ma = p1; mb = p5; end
        default: ;
      endcase
    end
  end

  // corner capture, differences and forward accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx1 <= '0; cx2 <= '0; cx3 <= '0; cx4 <= '0;
      cy1 <= '0; cy2 <= '0; cy3 <= '0; cy4 <= '0;
      dx14 <= '0; dx23 <= '0; dx12 <= '0; dx43 <= '0;
      dy23 <= '0; dy41 <= '0; dy34 <= '0;
      dy12 <= '0; dy42 <= '0;
      s7 <= '0; s8 <= '0; den <= '0;
      xd <= '0; yd <= '0;
      p1 <= '0; p2 <= '0; p4 <= '0; p5 <= '0;
    end else if (cap) begin
      cx1 <= {1'b0, x1}; cx2 <= {1'b0, x2};
      cx3 <= {1'b0, x3}; cx4 <= {1'b0, x4};
      cy1 <= {1'b0, y1}; cy2 <= {1'b0, y2};
      cy3 <= {1'b0, y3}; cy4 <= {1'b0, y4};
    end else if (dif_en) begin
      dx14 <= cx1 - cx4;
      dx23 <= cx2 - cx3;
      dx12 <= cx1 - cx2;
      dx43 <= cx4 - cx3;
      dy23 <= cy2 - cy3;
      dy41 <= cy4 - cy1;
      dy34 <= cy3 - cy4;
      dy12 <= cy1 - cy2;
      dy42 <= cy4 - cy2;
    end else if (fwd_en) begin
      case (cnt)
        5'd0:  s7  <= pf;
        5'd1:  s7  <= s7 + pf;
        5'd2:  s8  <= pf;
        5'd3:  s8  <= s8 + pf;
        5'd4:  den <= pf;
        5'd5:  den <= den + pf;
        5'd6:  den <= den + pf;
        5'd7:  xd  <= pf;
        5'd8:  yd  <= pf;
        5'd9:  p1  <= -pk7;
        5'd10: p2  <= -pk8;
        5'd11: p4  <= pk7;
        5'd12: p5  <= -pk8;
        5'd13: p1  <= p1 + pf;
        5'd14: p2  <= p2 + pf;
        5'd15: p4  <= p4 + pf;
        5'd16: p5  <= p5 + pf;
        default: ;
      endcase
    end
  end

  // adjugate: even step loads a product, odd step subtracts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) acc[i] <= '0;
    end else if (inv_en) begin
      if (cnt[0]) acc[aidx] <= acc[aidx] - AW'(prod);
      else        acc[aidx] <= AW'(prod);
    end
  end

  // result registers, updated only in the final step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_inv <= '0; p2_inv <= '0; p3_inv <= '0;
      p4_inv <= '0; p5_inv <= '0; p6_inv <= '0;
      p7_inv <= '0; p8_inv <= '0; p9_inv <= '0;
      dec_numx_horiz  <= '0;
      dec_numy_horiz  <= '0;
      dec_denom_horiz <= '0;
      degenerate      <= 1'b0;
    end else if (ld_en) begin
      p1_inv <= OW'(acc[0]);
      p2_inv <= OW'(acc[1]);
      p3_inv <= OW'(acc[2]);
      p4_inv <= OW'(acc[3]);
      p5_inv <= OW'(acc[4]);
      p6_inv <= OW'(acc[5]);
      p7_inv <= OW'(acc[6]);
      p8_inv <= OW'(acc[7]);
      p9_inv <= OW'(acc[8]);
      dec_numx_horiz  <= OW'(cmul(acc[0], HSCALE));
      dec_numy_horiz  <= OW'(cmul(acc[3], HSCALE));
      dec_denom_horiz <= OW'(cmul(acc[6], HSCALE));
      degenerate      <= (den == '0) || (acc[8] == '0);
    end
  end

endmodule
